// File: rtl/dmem_axil_pkg.sv
// Shared types and constants for the data-memory AXI4-Lite bridge.
// Latency: none (package only).
// Backpressure: none (package only).
package dmem_axil_pkg;

  // Bridge FSM states
  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RESP
  } state_t;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Data-memory window, shared with the core top
  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h8010_0000;
  localparam logic [31:0] DMEM_SIZE_DEFAULT = 32'h0001_0000;

endpackage

// File: rtl/dmem_axil_bridge.sv
// Core data-memory port to AXI4-Lite master bridge, one access in flight.
// Latency: zero-wait load/store responds 3 cycles after request, window fault 1 cycle.
// Backpressure: core_stall holds the core; AXI valids stay up until their handshake.
module dmem_axil_bridge
  import dmem_axil_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEFAULT,
  parameter logic [31:0] DMEM_SIZE = DMEM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  // core request / response
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        core_stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AXI4-Lite write address
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  // AXI4-Lite write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  // AXI4-Lite write response
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // AXI4-Lite read address
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  // AXI4-Lite read data
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  state_t      state;
  logic        aw_done;
  logic        w_done;
  logic [31:0] bus_addr;

  // 33-bit window compare so a window ending at 4 GiB does not wrap
  logic [32:0] addr_ext;
  logic [32:0] win_lo;
  logic [32:0] win_hi;
  logic        in_range;
  logic        aw_hs;
  logic        w_hs;

  assign addr_ext = {1'b0, req_addr};
  assign win_lo   = {1'b0, DMEM_BASE};
  assign win_hi   = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};
  assign in_range = (addr_ext >= win_lo) && (addr_ext < win_hi);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Reads and writes never overlap, so one address register serves both channels
  assign awaddr = bus_addr;
  assign araddr = bus_addr;

  // Stall while a request is pending; released in the response cycle
  assign core_stall = ((state != IDLE) || req_valid) && (state != RESP);

  // Bridge FSM with registered AXI and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      bus_addr   <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            bus_addr <= {req_addr[31:2], 2'b00};
            wdata    <= req_wdata;
            wstrb    <= req_wstrb;
            if (!in_range) begin
              // window fault: answer immediately, no bus activity
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end else if (req_wstrb == 4'b0000) begin
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end else begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR_REQ;
            end
          end
        end

        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_err   <= (rresp != OKAY);
            resp_rdata <= (rresp != OKAY) ? 32'h0 : rdata;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end

        WR_REQ: begin
          // AW and W complete independently, in either order or together
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_err   <= (bresp != OKAY);
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end

        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// Self-checking bench for dmem_axil_bridge with a configurable-wait AXI4-Lite slave.
// Latency: expected response cycle is carried in the scoreboard entry per request.
// Backpressure: slave wait counts per channel are set before each request.
module tb_dmem_axil_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        core_stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  dmem_axil_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .core_stall(core_stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // slave configuration
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = 2'b00;
  logic [1:0]  cfg_bresp = 2'b00;

  // slave observations
  int          n_ar = 0, n_aw = 0, n_w = 0, awv_cyc = 0, wv_cyc = 0, viol = 0, overlap = 0;
  logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          n_ar;
    int          n_aw;
    int          awv;
    int          wv;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_arvalid"},    32'(arvalid), 0);
    chk({tag, "_rready"},     32'(rready), 0);
    chk({tag, "_awvalid"},    32'(awvalid), 0);
    chk({tag, "_wvalid"},     32'(wvalid), 0);
    chk({tag, "_bready"},     32'(bready), 0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
    chk({tag, "_resp_err"},   32'(resp_err), 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_awaddr"},     awaddr, 0);
    chk({tag, "_araddr"},     araddr, 0);
    chk({tag, "_wdata"},      wdata, 0);
    chk({tag, "_wstrb"},      32'(wstrb), 0);
    chk({tag, "_stall"},      32'(core_stall), 0);
  endtask

  // AXI4-Lite slave: decides ready/valid at the negedge for the coming posedge
  initial begin : slave
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, rd_pend, aw_got, w_got, prev_arv, prev_awv, prev_wv;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; rd_pend = 0; aw_got = 0; w_got = 0;
    prev_arv = 0; prev_awv = 0; prev_wv = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; rd_pend = 0; aw_got = 0; w_got = 0;
        prev_arv = 0; prev_awv = 0; prev_wv = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
        awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      end else begin
        // consequences of the handshakes at the posedge just passed
        if (ar_hs) begin rd_pend = 1; r_cnt = 0; end
        if (r_hs) rd_pend = 0;
        if (aw_hs) aw_got = 1;
        if (w_hs) w_got = 1;
        if (b_hs) begin aw_got = 0; w_got = 0; b_cnt = 0; end
        // protocol observations
        if (prev_arv && !ar_hs && !arvalid) viol++;
        if (prev_awv && !aw_hs && !awvalid) viol++;
        if (prev_wv && !w_hs && !wvalid) viol++;
        if (arvalid && awvalid) overlap++;
        if (awvalid) awv_cyc++;
        if (wvalid) wv_cyc++;
        // AR
        if (arvalid) begin
          arready = (ar_cnt >= ar_wait);
          if (!arready) ar_cnt++;
        end else begin
          arready = 0; ar_cnt = 0;
        end
        ar_hs = arvalid && arready;
        if (ar_hs) begin n_ar++; last_araddr = araddr; end
        // R
        if (rd_pend && r_cnt >= r_wait) begin
          rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp;
        end else begin
          rvalid = 0; rdata = '0; rresp = 2'b00;
          if (rd_pend) r_cnt++;
        end
        r_hs = rvalid && rready;
        // AW
        if (awvalid) begin
          awready = (aw_cnt >= aw_wait);
          if (!awready) aw_cnt++;
        end else begin
          awready = 0; aw_cnt = 0;
        end
        aw_hs = awvalid && awready;
        if (aw_hs) begin n_aw++; last_awaddr = awaddr; end
        // W
        if (wvalid) begin
          wready = (w_cnt >= w_wait);
          if (!wready) w_cnt++;
        end else begin
          wready = 0; w_cnt = 0;
        end
        w_hs = wvalid && wready;
        if (w_hs) begin n_w++; last_wdata = wdata; last_wstrb = wstrb; end
        // B
        if (aw_got && w_got && b_cnt >= b_wait) begin
          bvalid = 1; bresp = cfg_bresp;
        end else begin
          bvalid = 0; bresp = 2'b00;
          if (aw_got && w_got) b_cnt++;
        end
        b_hs = bvalid && bready;
        prev_arv = arvalid; prev_awv = awvalid; prev_wv = wvalid;
      end
    end
  end

  // Issue one core request, push its expectation, and check it when resp_valid appears
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                        input int e_ar, input int e_aw, input int e_awv, input int e_wv);
    exp_t e;
    int   start, ar0, aw0, w0;
    bit   done;
    @(negedge clk);
    chk("idle_resp_valid", 32'(resp_valid), 0);
    chk("idle_stall", 32'(core_stall), 0);
    e.rdata = e_rdata; e.err = e_err; e.lat = e_lat; e.n_ar = e_ar; e.n_aw = e_aw;
    e.awv = e_awv; e.wv = e_wv; e.addr = {addr[31:2], 2'b00}; e.wdata = wd; e.wstrb = ws;
    sb.push_back(e);
    ar0 = n_ar; aw0 = n_aw; w0 = n_w; awv_cyc = 0; wv_cyc = 0;
    req_addr = addr; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    start = cyc;
    #1 chk("stall_c0", 32'(core_stall), 1);
    done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        done = 1;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("latency", cyc - start, e.lat);
        chk("stall_resp", 32'(core_stall), 0);
        chk("ar_count", n_ar - ar0, e.n_ar);
        chk("aw_count", n_aw - aw0, e.n_aw);
        chk("w_count", n_w - w0, e.n_aw);
        if (e.n_ar > 0) chk("araddr", last_araddr, e.addr);
        if (e.n_aw > 0) begin
          chk("awaddr", last_awaddr, e.addr);
          chk("wdata", last_wdata, e.wdata);
          chk("wstrb", 32'(last_wstrb), 32'(e.wstrb));
          chk("awvalid_cycles", awv_cyc, e.awv);
          chk("wvalid_cycles", wv_cyc, e.wv);
        end
        req_valid = 1'b0;
      end else begin
        chk("stall_wait", 32'(core_stall), 1);
      end
    end
    if (!done) begin
      chk("resp_timeout", 0, 1);
      void'(sb.pop_front());
      req_valid = 1'b0;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    #2 rst = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // load OK, zero-wait
    cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b00;
    do_req(32'h8010_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3, 1, 0, 0, 0);

    // store with AW delayed to cycle 4, W accepted at cycle 1
    aw_wait = 3;
    do_req(32'h8010_0004, 32'h0000_1234, 4'b0011, 32'h0, 1'b0, 6, 0, 1, 4, 1);
    aw_wait = 0;

    // zero-wait store to the last word of the window
    do_req(32'h8010_FFFC, 32'hA5A5_0000, 4'b1100, 32'h0, 1'b0, 3, 0, 1, 1, 1);

    // window faults: one past the end, below the base, and near 4 GiB
    do_req(32'h8011_0000, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 0, 0, 0);
    do_req(32'h8000_0000, 32'h0, 4'h0, 32'h0, 1'b1, 1, 0, 0, 0, 0);
    do_req(32'hFFFF_FFFC, 32'h55, 4'hF, 32'h0, 1'b1, 1, 0, 0, 0, 0);

    // slave error on read, then a clean read
    cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b10;
    do_req(32'h8010_0020, 32'h0, 4'h0, 32'h0, 1'b1, 3, 1, 0, 0, 0);
    cfg_rdata = 32'hCAFE_F00D; cfg_rresp = 2'b00;
    do_req(32'h8010_0024, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 3, 1, 0, 0, 0);

    // decode error on write
    cfg_bresp = 2'b11;
    do_req(32'h8010_0008, 32'h0000_00FF, 4'b0001, 32'h0, 1'b1, 3, 0, 1, 1, 1);
    cfg_bresp = 2'b00;

    // wait states: read address and data, then write data and response
    ar_wait = 1; r_wait = 2; cfg_rdata = 32'h0BAD_F00D;
    do_req(32'h8010_0040, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 6, 1, 0, 0, 0);
    ar_wait = 0; r_wait = 0;
    w_wait = 2; b_wait = 1;
    do_req(32'h8010_0044, 32'h7777_8888, 4'b1111, 32'h0, 1'b0, 6, 0, 1, 1, 3);
    w_wait = 0; b_wait = 0;

    // reset while a store waits for AW
    aw_wait = 10;
    @(negedge clk);
    req_addr = 32'h8010_0030; req_wdata = 32'h1; req_wstrb = 4'hF; req_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_awvalid", 32'(awvalid), 1);
    rst = 1'b0; req_valid = 1'b0;
    #1 chk_outputs_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1; aw_wait = 0;
    cfg_rdata = 32'h600D_0001;
    do_req(32'h8010_0050, 32'h0, 4'h0, 32'h600D_0001, 1'b0, 3, 1, 0, 0, 0);

    // back-to-back: unaligned load then store on consecutive requests
    cfg_rdata = 32'h1357_9BDF;
    do_req(32'h8010_0013, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, 3, 1, 0, 0, 0);
    do_req(32'h8010_0060, 32'hFEED_FACE, 4'b1010, 32'h0, 1'b0, 3, 0, 1, 1, 1);

    @(negedge clk);
    chk("final_resp_valid", 32'(resp_valid), 0);
    chk("valid_withdrawn", viol, 0);
    chk("ar_aw_overlap", overlap, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_axil_bridge.md
# dmem_axil_bridge

Data-memory bus bridge sitting directly downstream of the processor core's data-memory port. It accepts one load or store request at a time from the core, checks it against the data-memory window, and executes it as a single AXI4-Lite transaction. It returns the read data or completion with an error flag, and drives a stall signal that holds the core's PC until the access completes.

## Interface
- `DMEM_BASE`, default `32'h8010_0000`: first byte address of the data-memory window.
- `DMEM_SIZE`, default `32'h0001_0000`: window size in bytes; power of two, at least 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  core request present; core holds it and all `req_*` fields stable until the `resp_valid` cycle.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, already lane-aligned.
- `req_wstrb`  in  4  byte enables; `0` means load, non-zero means store.
- `core_stall`  out  1  high while a request is pending and not yet responded to.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load data; valid with `resp_valid`.
- `resp_err`  out  1  access fault; valid with `resp_valid`.
- AXI4-Lite master, 32-bit address and data, word-aligned:
  - `awaddr`/`awvalid`/`awready`
  - `wdata`/`wstrb`/`wvalid`/`wready`
  - `bresp[1:0]`/`bvalid`/`bready`
  - `araddr`/`arvalid`/`arready`
  - `rdata`/`rresp[1:0]`/`rvalid`/`rready`

## Operation
- States: `IDLE`, `RD_ADDR`, `RD_DATA`, `WR_REQ`, `WR_RESP`, `RESP`.
- **IDLE**
  - On `req_valid`, latch address, data and strobes.
  - `req_addr[1:0]` is forced to 0 on the bus.
  - In range means `DMEM_BASE <= addr < DMEM_BASE+DMEM_SIZE`, evaluated with 33-bit arithmetic so the window end does not wrap.
  - Out of range: go to `RESP` with the error flag set. No bus activity.
  - Load in range: go to `RD_ADDR`.
  - Store in range: go to `WR_REQ`.
- **RD_ADDR**
  - `arvalid=1`.
  - On `arready`, go to `RD_DATA`.
- **RD_DATA**
  - `rready=1`.
  - On `rvalid`, register `rdata` and set the error flag to `rresp!=2'b00`; the registered data is 0 if the error flag is set.
  - Go to `RESP`.
- **WR_REQ**
  - `awvalid` and `wvalid` both rise on entry.
  - Each drops independently after its own handshake; done flags `aw_done`/`w_done` track this.
  - AW and W handshakes may occur in the same cycle or in either order.
  - Go to `WR_RESP` once both are done.
- **WR_RESP**
  - `bready=1`.
  - On `bvalid`, set the error flag to `bresp!=2'b00`.
  - Go to `RESP`.
- **RESP**
  - `resp_valid=1` for exactly one cycle, then go to `IDLE`.
  - `resp_rdata` and `resp_err` hold their values until the next `RESP`.
- `core_stall = (state!=IDLE || req_valid) && state!=RESP` (combinational).
- No AXI valid signal is withdrawn before its handshake.
- One transaction outstanding at most; the bridge never issues AR and AW together.
- A `req_valid` seen in the cycle after `RESP` is a new request.

## Timing
- Reset (asynchronous, `rst=0`):
  - state goes to `IDLE`;
  - all AXI valid/ready outputs 0;
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`;
  - address, data and strobe outputs 0;
  - `aw_done` and `w_done` cleared.
- Reset mid-transaction abandons it; the slave is reset by the same `rst`.
- Load latency with a zero-wait slave (`arready` high, `rvalid` the cycle after AR): `req_valid` sampled at cycle 0, AR handshake at cycle 1, R at cycle 2, `resp_valid` at cycle 3.
- Store latency with a zero-wait slave: AW and W at cycle 1, B at cycle 2, `resp_valid` at cycle 3.
- Out-of-range access: `resp_valid` at cycle 1.
- Each slave wait cycle adds exactly one cycle.
- `core_stall` is high for cycles 0..N-1 and low in the `resp_valid` cycle N.
- AXI outputs are registered; none depends combinationally on a slave input.

## Structure
- Shared package `dmem_axil_pkg`:
  - state enum;
  - AXI response codes: `OKAY=2'b00`, `EXOKAY=2'b01`, `SLVERR=2'b10`, `DECERR=2'b11`;
  - default base and size constants, shared with the core top.
- No sub-module: the FSM, latches and range compare form a single module.

## Test plan
- **Load OK:** load from `0x8010_0010` with a zero-wait slave returning `0xDEAD_BEEF`/`OKAY` → `araddr=0x8010_0010`, `resp_valid` at cycle 3, `resp_rdata=0xDEAD_BEEF`, `resp_err=0`.
- **Store, AW delayed:** store `wstrb=4'b0011`, `wdata=0x0000_1234` to `0x8010_0004`; `wready` at cycle 1, `awready` delayed to cycle 4 → `wvalid` drops after cycle 1, `awvalid` holds through cycle 4, `bready` from cycle 5, `resp_valid` the cycle after `bvalid`.
- **Range fault:** loads at `0x8011_0000` and `0x8000_0000` → no AR issued, `resp_valid` at cycle 1 with `resp_err=1`, `resp_rdata=0`.
- **Bus error:** slave returns `rresp=SLVERR` → `resp_err=1`, `resp_rdata=0`; the next load, returning `OKAY`, gives `resp_err=0`.
- **Reset mid-operation:** `rst` asserted low while in `WR_REQ` with `awvalid` high → all outputs 0 immediately; after release, a new load completes normally.
- **Back-to-back:** load then store on consecutive core requests → exactly one AR then one AW/W; each `resp_valid` is exactly one cycle; `core_stall` is low only in the `RESP` cycles.
